// File: rtl/regfile_mp.sv
// Multi-port integer register file with write priority, write-to-read bypass
// and a per-register busy scoreboard for issue/writeback tracking.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_sel,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_sel,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic [NUM_WR-1:0]        wr_clr,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_sel,
  output logic                     wr_conflict
);

  // Every encodable index gets a slot; slots 0 and >= NREGS are never
  // written, so they read back as zero and never become busy.
  localparam int   NSLOT = 1 << AW;
  localparam logic BYP   = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q   [NSLOT];
  logic [XLEN-1:0]  win_data [NSLOT];
  logic [NSLOT-1:0] win_en;
  logic [NSLOT-1:0] clr_hit;
  logic [NSLOT-1:0] iss_hit;
  logic [NSLOT-1:0] busy_q;
  logic [NSLOT-1:0] busy_d;
  logic             conflict_d;
  logic             conflict_q;

  // Per-register write resolution: ascending port scan so the highest port wins.
  // Qualified by rst_n so a write or issue presented during reset is neither
  // forwarded nor recorded.
  always_comb begin
    win_en     = '0;
    clr_hit    = '0;
    iss_hit    = '0;
    busy_d     = '0;
    conflict_d = 1'b0;
    for (int r = 0; r < NSLOT; r++) win_data[r] = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (rst_n && wr_en[j] && (wr_sel[j*AW +: AW] == AW'(r))) begin
          if (win_en[r]) conflict_d = 1'b1;
          win_en[r]   = 1'b1;
          win_data[r] = wr_data[j*XLEN +: XLEN];
          if (wr_clr[j]) clr_hit[r] = 1'b1;
        end
      end
      iss_hit[r] = rst_n && iss_en && (iss_sel == AW'(r));
      // Issue wins over a same-cycle clear: the new writer is still outstanding.
      busy_d[r]  = iss_hit[r] ? 1'b1 : (clr_hit[r] ? 1'b0 : busy_q[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NSLOT; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < NSLOT; r++) begin
        if (win_en[r]) regs_q[r] <= win_data[r];
      end
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  // A clearing write on the read register makes the operand ready this cycle
  // only when its data can be forwarded.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (BYP && win_en[rd_sel[k*AW +: AW]])
        rd_data[k*XLEN +: XLEN] = win_data[rd_sel[k*AW +: AW]];
      else
        rd_data[k*XLEN +: XLEN] = regs_q[rd_sel[k*AW +: AW]];
      rd_busy[k] = busy_q[rd_sel[k*AW +: AW]] &&
                   !(BYP && clr_hit[rd_sel[k*AW +: AW]] && !iss_hit[rd_sel[k*AW +: AW]]);
    end
  end

  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default bypassing instance, a non-bypassing
// 20-register instance and a 16-register three-read-port instance.
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // Instance a: defaults (32 regs, 2R/2W, bypass)
  logic [9:0]  a_rd_sel;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_sel;
  logic [63:0] a_wr_data;
  logic [1:0]  a_wr_clr;
  logic        a_iss_en;
  logic [4:0]  a_iss_sel;
  logic        a_wr_conflict;

  // Instance b: 20 regs, no bypass
  logic [9:0]  b_rd_sel;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_sel;
  logic [63:0] b_wr_data;
  logic [1:0]  b_wr_clr;
  logic        b_iss_en;
  logic [4:0]  b_iss_sel;
  logic        b_wr_conflict;

  // Instance c: 16 regs, 3 read ports
  logic [11:0] c_rd_sel;
  logic [95:0] c_rd_data;
  logic [2:0]  c_rd_busy;
  logic [1:0]  c_wr_en;
  logic [7:0]  c_wr_sel;
  logic [63:0] c_wr_data;
  logic [1:0]  c_wr_clr;
  logic        c_iss_en;
  logic [3:0]  c_iss_sel;
  logic        c_wr_conflict;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .rd_sel(a_rd_sel), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_data(a_wr_data), .wr_clr(a_wr_clr),
    .iss_en(a_iss_en), .iss_sel(a_iss_sel), .wr_conflict(a_wr_conflict)
  );

  regfile_mp #(.NREGS(20), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_sel(b_rd_sel), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data), .wr_clr(b_wr_clr),
    .iss_en(b_iss_en), .iss_sel(b_iss_sel), .wr_conflict(b_wr_conflict)
  );

  regfile_mp #(.NREGS(16), .NUM_RD(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_sel(c_rd_sel), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_sel(c_wr_sel), .wr_data(c_wr_data), .wr_clr(c_wr_clr),
    .iss_en(c_iss_en), .iss_sel(c_iss_sel), .wr_conflict(c_wr_conflict)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_wr_en = '0; a_wr_clr = '0; a_iss_en = 1'b0;
    b_wr_en = '0; b_wr_clr = '0; b_iss_en = 1'b0;
    c_wr_en = '0; c_wr_clr = '0; c_iss_en = 1'b0;
  endtask

  task automatic a_write(input int port, input logic [4:0] sel, input logic [31:0] data,
                         input logic clr);
    a_wr_en[port]            = 1'b1;
    a_wr_sel[port*5 +: 5]    = sel;
    a_wr_data[port*32 +: 32] = data;
    a_wr_clr[port]           = clr;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    a_rd_sel = '0; a_wr_sel = '0; a_wr_data = '0; a_iss_sel = '0;
    b_rd_sel = '0; b_wr_sel = '0; b_wr_data = '0; b_iss_sel = '0;
    c_rd_sel = '0; c_wr_sel = '0; c_wr_data = '0; c_iss_sel = '0;
    idle_all();
    a_write(0, 5'd5, 32'h0000_DEAD, 1'b0);
    a_iss_en = 1'b1; a_iss_sel = 5'd5;
    a_rd_sel[4:0] = 5'd5;
    #2;
    checks++;
    if (a_rd_data[31:0] !== 32'h0) begin
      errors++; $display("FAIL reset_no_fwd: got %h want %h", a_rd_data[31:0], 32'h0);
    end
    tick(); tick();
    checks++;
    if (a_rd_data[31:0] !== 32'h0 || a_rd_busy !== 2'b00 || a_wr_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got data=%h busy=%b conf=%b want 0/00/0",
                         a_rd_data[31:0], a_rd_busy, a_wr_conflict);
    end
    idle_all();
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (a_rd_data[31:0] !== 32'h0 || a_rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_x5: got data=%h busy=%b want 0/0", a_rd_data[31:0], a_rd_busy[0]);
    end
    for (int i = 0; i < 32; i++) begin
      a_rd_sel[9:5] = 5'(i);
      #1;
      got = a_rd_data[63:32];
      checks++;
      if (got !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h want %h", i, got, 32'h0);
      end
    end
  endtask

  task automatic test_bypass();
    tick();
    a_write(0, 5'd3, 32'h0000_1234, 1'b0);
    b_wr_en[0] = 1'b1; b_wr_sel[4:0] = 5'd3; b_wr_data[31:0] = 32'h0000_1234;
    a_rd_sel[4:0] = 5'd3;
    b_rd_sel[4:0] = 5'd3;
    #2;
    checks++;
    if (a_rd_data[31:0] !== 32'h0000_1234) begin
      errors++; $display("FAIL bypass_same_cycle: got %h want %h", a_rd_data[31:0], 32'h1234);
    end
    checks++;
    if (b_rd_data[31:0] !== 32'h0) begin
      errors++; $display("FAIL nobypass_same_cycle: got %h want %h", b_rd_data[31:0], 32'h0);
    end
    tick();
    idle_all();
    #1;
    checks++;
    if (b_rd_data[31:0] !== 32'h0000_1234 || a_rd_data[31:0] !== 32'h0000_1234) begin
      errors++; $display("FAIL write_next_cycle: got a=%h b=%h want 00001234",
                         a_rd_data[31:0], b_rd_data[31:0]);
    end
  endtask

  task automatic test_collision();
    a_write(0, 5'd7, 32'h0000_AAAA, 1'b0);
    a_write(1, 5'd7, 32'h0000_5555, 1'b0);
    a_rd_sel[4:0] = 5'd7;
    #2;
    checks++;
    if (a_rd_data[31:0] !== 32'h0000_5555 || a_wr_conflict !== 1'b0) begin
      errors++; $display("FAIL collide_fwd: got data=%h conf=%b want 00005555/0",
                         a_rd_data[31:0], a_wr_conflict);
    end
    tick();
    idle_all();
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h0000_5555) begin
      errors++; $display("FAIL collide_win: got %h want %h", a_rd_data[31:0], 32'h5555);
    end
    checks++;
    if (a_wr_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_pulse: got %b want 1", a_wr_conflict);
    end
    tick();
    checks++;
    if (a_wr_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_drop: got %b want 0", a_wr_conflict);
    end
  endtask

  task automatic test_x0();
    a_write(0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    a_iss_en = 1'b1; a_iss_sel = 5'd0;
    a_rd_sel = '0;
    #2;
    checks++;
    if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      errors++; $display("FAIL x0_same_cycle: got data=%h busy=%b want 0/00", a_rd_data, a_rd_busy);
    end
    tick();
    idle_all();
    #1;
    checks++;
    if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      errors++; $display("FAIL x0_after: got data=%h busy=%b want 0/00", a_rd_data, a_rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    a_rd_sel[4:0] = 5'd9;
    a_iss_en = 1'b1; a_iss_sel = 5'd9;
    #2;
    checks++;
    if (a_rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL busy_before_edge: got %b want 0", a_rd_busy[0]);
    end
    tick(); idle_all(); #1;
    checks++;
    if (a_rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL busy_set: got %b want 1", a_rd_busy[0]);
    end
    tick();
    a_write(1, 5'd9, 32'h0000_0042, 1'b1);
    #2;
    checks++;
    if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h42) begin
      errors++; $display("FAIL clr_bypass: got busy=%b data=%h want 0/00000042",
                         a_rd_busy[0], a_rd_data[31:0]);
    end
    tick(); idle_all(); #1;
    checks++;
    if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h42) begin
      errors++; $display("FAIL clr_done: got busy=%b data=%h want 0/00000042",
                         a_rd_busy[0], a_rd_data[31:0]);
    end
    a_iss_en = 1'b1; a_iss_sel = 5'd9;
    a_write(0, 5'd9, 32'h0000_0077, 1'b1);
    tick(); idle_all(); #1;
    checks++;
    if (a_rd_busy[0] !== 1'b1 || a_rd_data[31:0] !== 32'h77) begin
      errors++; $display("FAIL set_beats_clr: got busy=%b data=%h want 1/00000077",
                         a_rd_busy[0], a_rd_data[31:0]);
    end
    a_write(1, 5'd9, 32'h0000_0088, 1'b0);
    #2;
    checks++;
    if (a_rd_busy[0] !== 1'b1 || a_rd_data[31:0] !== 32'h88) begin
      errors++; $display("FAIL noclr_write: got busy=%b data=%h want 1/00000088",
                         a_rd_busy[0], a_rd_data[31:0]);
    end
    tick(); idle_all();
    a_iss_en = 1'b1; a_iss_sel = 5'd9;
    a_write(0, 5'd9, 32'h0000_0099, 1'b1);
    #2;
    checks++;
    if (a_rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL iss_blocks_ready: got %b want 1", a_rd_busy[0]);
    end
    tick(); idle_all();
    a_write(0, 5'd9, 32'h0000_0099, 1'b1);
    tick(); idle_all(); #1;
    checks++;
    if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h99) begin
      errors++; $display("FAIL final_clear: got busy=%b data=%h want 0/00000099",
                         a_rd_busy[0], a_rd_data[31:0]);
    end
  endtask

  task automatic test_independent();
    a_iss_en = 1'b1; a_iss_sel = 5'd10;
    a_write(0, 5'd11, 32'h0000_1111, 1'b1);
    a_rd_sel = {5'd11, 5'd10};
    tick(); idle_all(); #1;
    checks++;
    if (a_rd_busy !== 2'b01 || a_rd_data[63:32] !== 32'h1111) begin
      errors++; $display("FAIL independent: got busy=%b data1=%h want 01/00001111",
                         a_rd_busy, a_rd_data[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    a_rd_sel = {5'd10, 5'd3};
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h0 || a_rd_busy !== 2'b00) begin
      errors++; $display("FAIL async_reset: got data=%h busy=%b want 0/00", a_rd_data[31:0], a_rd_busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_range();
    b_wr_en[0] = 1'b1; b_wr_sel[4:0] = 5'd20; b_wr_data[31:0] = 32'h0000_0BAD;
    b_iss_en = 1'b1; b_iss_sel = 5'd21;
    b_rd_sel = {5'd21, 5'd20};
    tick(); idle_all(); #1;
    checks++;
    if (b_rd_data[31:0] !== 32'h0 || b_rd_busy !== 2'b00) begin
      errors++; $display("FAIL out_of_range: got data=%h busy=%b want 0/00", b_rd_data[31:0], b_rd_busy);
    end
  endtask

  task automatic test_small();
    c_wr_en[0] = 1'b1; c_wr_sel[3:0] = 4'd15; c_wr_data[31:0] = 32'h0000_CAFE;
    tick(); idle_all();
    c_rd_sel = {4'd15, 4'd15, 4'd15};
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (c_rd_data[k*32 +: 32] !== 32'h0000_CAFE) begin
        errors++; $display("FAIL small_port%0d: got %h want %h", k, c_rd_data[k*32 +: 32], 32'hCAFE);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_bypass();
    test_collision();
    test_x0();
    test_scoreboard();
    test_independent();
    test_reset_mid();
    test_range();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
